// File: rtl/jnwtr_ckdiv_prog.sv
// Programmable integer clock divider with a single-cycle pulse output and a near-50% divided clock.
// A new ratio takes effect only on a period boundary, and a stop request finishes the current period before the divider goes idle.
module jnwtr_ckdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CKI,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             CKO,
  output logic             CKO50DC,
  output logic             LOAD_ACK,
  output logic             BUSY,
  output logic [WIDTH-1:0] CNT
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_pend_val;
  logic             r_pend;
  logic             r_cko;
  logic             r_c50;
  logic             r_ack;
  logic             r_busy;

  state_t           w_state_nx;
  logic [WIDTH-1:0] w_cnt_nx;
  logic [WIDTH-1:0] w_n_nx;
  logic [WIDTH-1:0] w_pend_val_nx;
  logic             w_pend_nx;
  logic             w_cko_nx;
  logic             w_c50_nx;
  logic             w_ack_nx;
  logic [WIDTH-1:0] w_div_clamped;
  logic             w_wrap;

  assign w_div_clamped = (DIV < WIDTH'(2)) ? WIDTH'(2) : DIV;
  assign w_wrap        = (r_cnt == (r_n - WIDTH'(1)));

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_n_nx        = r_n;
    w_pend_val_nx = LOAD ? w_div_clamped : r_pend_val;
    w_pend_nx     = r_pend | LOAD;
    w_cko_nx      = 1'b0;
    w_c50_nx      = 1'b0;
    w_ack_nx      = 1'b0;

    case (r_state)
      ST_OFF: begin
        w_cnt_nx = '0;
        if (EN) begin
          // Starting up: DIV at this edge wins over anything left pending.
          w_state_nx = ST_RUN;
          w_n_nx     = w_div_clamped;
          w_pend_nx  = 1'b0;
          w_cko_nx   = 1'b1;
          w_c50_nx   = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (w_wrap) begin
          w_cnt_nx = '0;
          if (r_pend) begin
            // The pending ratio is applied; a LOAD on this same edge re-arms for the next wrap.
            w_n_nx    = r_pend_val;
            w_ack_nx  = 1'b1;
            w_pend_nx = LOAD;
          end
        end else begin
          w_cnt_nx = r_cnt + WIDTH'(1);
        end
        w_cko_nx = (w_cnt_nx == '0);
        w_c50_nx = ({1'b0, w_cnt_nx} < (({1'b0, w_n_nx} + (WIDTH+1)'(1)) >> 1));
        if ((r_state == ST_DRAIN) && w_wrap && !EN) begin
          // Stop exactly at the period boundary; suppress the wrap-high so no runt phase appears.
          w_state_nx = ST_OFF;
          w_cko_nx   = 1'b0;
          w_c50_nx   = 1'b0;
        end else begin
          w_state_nx = EN ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        w_state_nx = ST_OFF;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CKI or negedge RN) begin
    if (!RN) begin
      r_state    <= ST_OFF;
      r_cnt      <= '0;
      r_n        <= WIDTH'(2);
      r_pend_val <= WIDTH'(2);
      r_pend     <= 1'b0;
      r_cko      <= 1'b0;
      r_c50      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_n        <= w_n_nx;
      r_pend_val <= w_pend_val_nx;
      r_pend     <= w_pend_nx;
      r_cko      <= w_cko_nx;
      r_c50      <= w_c50_nx;
      r_ack      <= w_ack_nx;
      r_busy     <= (w_state_nx != ST_OFF);
    end
  end

  assign CKO      = r_cko;
  assign CKO50DC  = r_c50;
  assign LOAD_ACK = r_ack;
  assign BUSY     = r_busy;
  assign CNT      = r_cnt;

endmodule

// File: tb/tb_jnwtr_ckdiv_prog.sv
// Bench for jnwtr_ckdiv_prog: directed scenarios with literal expectations plus a long randomized run,
// all compared every cycle against a behavioural period/phase model.
module tb_jnwtr_ckdiv_prog;
  localparam int WIDTH = 4;

  logic             CKI;
  logic             RN;
  logic             EN;
  logic [WIDTH-1:0] DIV;
  logic             LOAD;
  logic             CKO;
  logic             CKO50DC;
  logic             LOAD_ACK;
  logic             BUSY;
  logic [WIDTH-1:0] CNT;

  jnwtr_ckdiv_prog #(.WIDTH(WIDTH)) dut (
    .CKI(CKI), .RN(RN), .EN(EN), .DIV(DIV), .LOAD(LOAD),
    .CKO(CKO), .CKO50DC(CKO50DC), .LOAD_ACK(LOAD_ACK), .BUSY(BUSY), .CNT(CNT)
  );

  initial begin
    CKI = 1'b0;
    forever #5 CKI = ~CKI;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: position within the current output period and the ratio of that period.
  bit m_running;
  bit m_stopping;
  int m_phase;
  int m_n;
  int m_pend_val;
  bit m_pend;
  bit m_ack;

  function automatic int clampdiv(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int exp_cko();
    return (m_running && m_phase == 0) ? 1 : 0;
  endfunction

  function automatic int exp_c50();
    return (m_running && m_phase < (m_n + 1) / 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_running  = 0;
    m_stopping = 0;
    m_phase    = 0;
    m_n        = 2;
    m_pend_val = 2;
    m_pend     = 0;
    m_ack      = 0;
  endtask

  task automatic model_step(input bit en, input int div, input bit ld);
    bit period_end;
    if (!m_running) begin
      m_ack = 0;
      if (ld) begin m_pend_val = clampdiv(div); m_pend = 1; end
      if (en) begin
        m_running  = 1;
        m_stopping = 0;
        m_n        = clampdiv(div);
        m_phase    = 0;
        m_pend     = 0;
      end
    end else begin
      period_end = (m_phase == m_n - 1);
      m_ack = period_end && m_pend;
      if (period_end && m_pend) begin m_n = m_pend_val; m_pend = 0; end
      if (ld) begin m_pend_val = clampdiv(div); m_pend = 1; end
      m_phase = period_end ? 0 : m_phase + 1;
      if (m_stopping && period_end && !en) begin
        m_running  = 0;
        m_stopping = 0;
      end else begin
        m_stopping = !en;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cnt", int'(CNT), m_phase);
    chk("cko", int'(CKO), exp_cko());
    chk("cko50dc", int'(CKO50DC), exp_c50());
    chk("load_ack", int'(LOAD_ACK), int'(m_ack));
    chk("busy", int'(BUSY), int'(m_running));
  endtask

  task automatic cyc(input bit en, input int div, input bit ld);
    EN   = en;
    DIV  = WIDTH'(div);
    LOAD = ld;
    @(posedge CKI);
    model_step(en, div, ld);
    #1;
    compare_all();
    $display("cyc t=%0t en=%0d div=%0d ld=%0d -> cnt=%0d cko=%0d c50=%0d ack=%0d busy=%0d",
             $time, en, div, ld, CNT, CKO, CKO50DC, LOAD_ACK, BUSY);
    LOAD = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cnt"}, int'(CNT), 0);
    chk({tag, "_cko"}, int'(CKO), 0);
    chk({tag, "_cko50dc"}, int'(CKO50DC), 0);
    chk({tag, "_ack"}, int'(LOAD_ACK), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
  endtask

  // Called just after a compare; pulses RN between clock edges.
  task automatic reset_pulse();
    #2 RN = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #1 RN = 1'b1;
  endtask

  task automatic drain_to_off();
    int guard;
    guard = 0;
    while (m_running && guard < 40) begin
      cyc(0, 0, 0);
      guard++;
    end
    chk("stop_bound", int'(BUSY), 0);
  endtask

  initial begin
    int exp_cnt4[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_c504[9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    int exp_c505[6] = '{1, 1, 1, 0, 0, 1};
    int exp_cnt6[8] = '{3, 4, 5, 0, 1, 2, 0, 1};
    int exp_ack6[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int ack_sum;
    int max_cnt;

    RN = 1'b0; EN = 1'b0; DIV = '0; LOAD = 1'b0;
    model_reset();
    #12 check_all_zero("reset");
    #1 RN = 1'b1;

    // N=4 from OFF.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 4, 0);
      chk("n4_cnt_lit", int'(CNT), exp_cnt4[i]);
      chk("n4_c50_lit", int'(CKO50DC), exp_c504[i]);
      chk("n4_cko_lit", int'(CKO), (exp_cnt4[i] == 0) ? 1 : 0);
    end
    drain_to_off();

    // N=5: three high, two low.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 5, 0);
      chk("n5_c50_lit", int'(CKO50DC), exp_c505[i]);
    end
    drain_to_off();

    // DIV=0 and DIV=1 clamp to period 2.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1, d, 0);
        chk("clamp_cnt_lit", int'(CNT), i % 2);
      end
      drain_to_off();
    end

    // N=6, LOAD 3 while CNT=2.
    cyc(1, 6, 0);
    cyc(1, 6, 0);
    cyc(1, 6, 0);
    chk("n6_at2_lit", int'(CNT), 2);
    cyc(1, 3, 1);
    chk("n6_load_cnt_lit", int'(CNT), exp_cnt6[0]);
    for (int i = 1; i < 8; i++) begin
      cyc(1, 3, 0);
      chk("n6_cnt_lit", int'(CNT), exp_cnt6[i]);
      chk("n6_ack_lit", int'(LOAD_ACK), exp_ack6[i]);
    end
    drain_to_off();

    // N=4, EN dropped at CNT=1: CNT 2,3 then OFF.
    cyc(1, 4, 0);
    cyc(1, 4, 0);
    chk("drain_at1_lit", int'(CNT), 1);
    cyc(0, 4, 0); chk("drain_cnt2_lit", int'(CNT), 2); chk("drain_busy2_lit", int'(BUSY), 1);
    cyc(0, 4, 0); chk("drain_cnt3_lit", int'(CNT), 3);
    cyc(0, 4, 0); chk("drain_off_busy_lit", int'(BUSY), 0); chk("drain_off_cko_lit", int'(CKO), 0);
    chk("drain_off_c50_lit", int'(CKO50DC), 0);

    // EN re-raised at CNT=2 keeps running without a glitch.
    cyc(1, 4, 0);
    cyc(1, 4, 0);
    cyc(0, 4, 0);
    cyc(1, 4, 0); chk("rerun_cnt_lit", int'(CNT), 3); chk("rerun_c50_lit", int'(CKO50DC), 0);
    cyc(1, 4, 0); chk("rerun_wrap_lit", int'(CKO), 1); chk("rerun_busy_lit", int'(BUSY), 1);

    // LOAD 7 then LOAD 9 before the wrap: one ack, period 9.
    cyc(1, 4, 0);
    cyc(1, 7, 1);
    cyc(1, 9, 1);
    ack_sum = 0;
    max_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 9, 0);
      ack_sum += int'(LOAD_ACK);
      if (int'(CNT) > max_cnt) max_cnt = int'(CNT);
    end
    chk("double_load_ack_lit", ack_sum, 1);
    chk("double_load_max_cnt_lit", max_cnt, 8);
    drain_to_off();

    // N=8, reset at CNT=3 with EN held, then restart.
    cyc(1, 8, 0);
    cyc(1, 8, 0); cyc(1, 8, 0); cyc(1, 8, 0);
    chk("n8_at3_lit", int'(CNT), 3);
    EN = 1'b1;
    reset_pulse();
    cyc(1, 8, 0);
    chk("restart_cnt_lit", int'(CNT), 0);
    chk("restart_cko_lit", int'(CKO), 1);
    chk("restart_busy_lit", int'(BUSY), 1);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) != 0), int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 299) == 0) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
